dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM (2048 x 32) between two requesters: the CPU load/store port (port 0)
//  and the debug/loader port (port 1). Translates 32-bit virtual byte addresses (global and stack
//  windows) to 11-bit word indices, flags invalid accesses, and sequences the synchronous RAM.
//  Sits between the MIPS32 core / debug unit and the data-memory macro.
// PARAMETERS
//  DATA_W   32  data bus width
//  ADDR_W   11  RAM word-index width (1024 global words + 1024 stack words)
//  RR_EN    1   1: round-robin arbitration; 0: fixed priority, CPU always wins
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU request; held high until cpu_ack
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   32      virtual byte address
//  cpu_wdata  in   DATA_W  store data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_err    out  1       valid with cpu_ack: invalid/unaligned address
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack/dbg_err   same as cpu_* for port 1
//  rdata      out  DATA_W  load data, valid only in the cycle of an ack with err=0, we=0
//  ram_en     out  1       RAM access strobe
//  ram_we     out  1       RAM write enable (qualified by ram_en)
//  ram_addr   out  ADDR_W  RAM word index
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, one cycle after the ram_en edge
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, rr pointer=0 (CPU favoured). Reset mid-transaction aborts it:
//    no ack is issued, ram_en drops immediately; requesters re-issue.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Error path IDLE -> RESP.
//  - IDLE: if any req, select a winner; latch port id, we, translated address, wdata.
//    RR_EN=1: the port not served last wins on contention; RR_EN=0: CPU wins. A single request wins
//    outright. Pointer updates only when a grant is taken.
//  - Translation: 0x10010000..0x10010FFF -> {1'b0, addr[11:2]}; 0x7FFFF000..0x7FFFFFFF ->
//    {1'b1, addr[11:2]}. Outside both windows, or addr[1:0]!=0 -> error.
//  - Error: IDLE -> RESP, no RAM strobe; ack+err on winner in RESP (latency 1 cycle from req).
//  - Valid: ACCESS drives ram_en=1, ram_we/addr/wdata from latches for exactly one cycle.
//    RESP pulses winner ack (err=0); rdata=ram_rdata for loads, 0 otherwise. Latency: req at N -> ack N+2.
//  - Back in IDLE at N+3; the earliest next grant is the N+3 edge. Max throughput 1 access per 3 cycles.
//  - req dropped before ack: transaction still completes and ack is still pulsed (requester ignores it).
//  - The loser's req is ignored until the next IDLE; it is served next under RR_EN=1.
//  - Never both acks high; ack/err registered; rdata gated to 0 outside load acks.
// CONFIGURATION
//  DMEM_ARB_FAULT_LOG_EN defined: adds outputs fault_cnt[15:0] (saturating count of error responses)
//  and fault_addr[31:0] (virtual address of the most recent error); both reset to 0, updated in RESP.
//  Undefined: neither port nor logic exists; behaviour otherwise identical.
// STRUCTURE
//  Package dmem_pkg: window base/limit constants (GP_BASE, GP_LIMIT, SP_BASE, SP_LIMIT), FSM state
//  encoding (ST_IDLE, ST_ACCESS, ST_RESP), port ids (PORT_CPU=0, PORT_DBG=1).
//  Sub-module dmem_addr_xlate: combinational virtual->word index + invalid flag, one instance per port.
// TESTING
//  1 CPU load 0x10010008, RAM[2]=0xCAFEF00D -> ram_en at N+1 addr=0x002; cpu_ack N+2, rdata=0xCAFEF00D.
//  2 DBG store 0x7FFFF004 data 0x12345678 -> ram_we=1 addr=0x401 wdata=0x12345678; dbg_ack N+2, err=0.
//  3 CPU load 0x00000000 -> no ram_en; cpu_ack+cpu_err at N+1; fault_cnt 0->1, fault_addr=0 if enabled.
//  4 Both req same cycle, RR_EN=1, back-to-back x4 -> acks alternate CPU,DBG,CPU,DBG, 3-cycle spacing.
//  5 Unaligned 0x10010002 -> err; boundary 0x10010FFC -> addr 0x3FF ok; 0x10011000 -> err.
//  6 rst_n low during ACCESS -> ram_en 0 asynchronously; no ack; busy 0; next req served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: address windows, FSM encoding and port ids shared by the data-memory arbiter.
package dmem_pkg;
  localparam logic [31:0] GP_BASE  = 32'h1001_0000;
  localparam logic [31:0] GP_LIMIT = 32'h1001_0FFF;
  localparam logic [31:0] SP_BASE  = 32'h7FFF_F000;
  localparam logic [31:0] SP_LIMIT = 32'h7FFF_FFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} dmemState;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/dmem_addr_xlate.sv
// dmem_addr_xlate: maps a virtual byte address onto a RAM word index and flags invalid accesses.
module dmem_addr_xlate import dmem_pkg::*; #(
  parameter int ADDR_W = 11
) (
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] idx,
  output logic              invalid
);
  logic inGp, inSp;
  assign inGp = addr >= GP_BASE && addr <= GP_LIMIT;
  assign inSp = addr >= SP_BASE && addr <= SP_LIMIT;
  assign invalid = !(inGp || inSp) || addr[1:0] != 2'b00;
  // stack window occupies the upper half of the RAM
  assign idx = ADDR_W'({inSp, addr[11:2]});
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and debug ports.
// Define DMEM_ARB_FAULT_LOG_EN to add the fault_cnt/fault_addr error log outputs.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
`ifdef DMEM_ARB_FAULT_LOG_EN
  ,
  output logic [15:0]       fault_cnt,
  output logic [31:0]       fault_addr
`endif
);
  dmemState state, nextState;
  logic [ADDR_W-1:0] cpuIdx, dbgIdx;
  logic cpuInvalid, dbgInvalid, rrPtr, winner, grant, go, selInvalid, selWe;
  logic portQ, weQ, toResp, respPort, respErr, ackLoad;

  dmem_addr_xlate #(.ADDR_W(ADDR_W)) cpuXlate (.addr(cpu_addr), .idx(cpuIdx), .invalid(cpuInvalid));
  dmem_addr_xlate #(.ADDR_W(ADDR_W)) dbgXlate (.addr(dbg_addr), .idx(dbgIdx), .invalid(dbgInvalid));

  // rrPtr names the port that wins the next contended grant
  assign grant = state == ST_IDLE && (cpu_req || dbg_req);
  assign winner = cpu_req && dbg_req ? (RR_EN ? rrPtr : PORT_CPU) : dbg_req;
  assign selInvalid = winner ? dbgInvalid : cpuInvalid;
  assign selWe = winner ? dbg_we : cpu_we;
  assign go = grant && !selInvalid;
  assign busy = state != ST_IDLE;
  assign rdata = ackLoad ? ram_rdata : '0;

  always_comb begin
    nextState = grant ? (selInvalid ? ST_RESP : ST_ACCESS) : state == ST_ACCESS ? ST_RESP : ST_IDLE;
    toResp = nextState == ST_RESP;
    respPort = grant ? winner : portQ;
    respErr = grant && selInvalid;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nextState;

  // RAM strobes and acks are registered on entry to ACCESS / RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rrPtr <= PORT_CPU;
      portQ <= PORT_CPU;
      weQ <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      cpu_err <= 1'b0;
      dbg_err <= 1'b0;
      ackLoad <= 1'b0;
    end else begin
      if (grant) begin
        rrPtr <= !winner;
        portQ <= winner;
        weQ <= selWe;
      end
      ram_en <= go;
      ram_we <= go && selWe;
      ram_addr <= go ? (winner ? dbgIdx : cpuIdx) : '0;
      ram_wdata <= go ? (winner ? dbg_wdata : cpu_wdata) : '0;
      cpu_ack <= toResp && respPort == PORT_CPU;
      dbg_ack <= toResp && respPort == PORT_DBG;
      cpu_err <= respErr && winner == PORT_CPU;
      dbg_err <= respErr && winner == PORT_DBG;
      ackLoad <= state == ST_ACCESS && !weQ;
    end

`ifdef DMEM_ARB_FAULT_LOG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fault_cnt <= '0;
      fault_addr <= '0;
    end else if (respErr) begin
      fault_cnt <= fault_cnt + {15'd0, fault_cnt != 16'hFFFF};
      fault_addr <= winner ? dbg_addr : cpu_addr;
    end
`endif
endmodule
